telemetry_rx: RTL

Receives the eBike serial telemetry stream on the `TX` line and recovers the battery, current and torque readings. It is a UART receiver (8N1) followed by a packet parser. It sits directly downstream of `eBike`, in the bench and on the lab monitor board, and drives the `BATT_TX`, `CURR_TX`, `TORQUE_TX` and `vld_TX` checks. Each complete, well-formed packet produces one-cycle `vld` and updates the held readings.

---
 rtl/telemetry_rx.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/telemetry_rx.sv
// telemetry_rx
// Receives the eBike serial telemetry stream (UART 8N1) and recovers the
// battery, current and torque readings from 8-byte packets
// (0xAA, 0x55, BATT hi/lo, CURR hi/lo, TORQUE hi/lo; each hi byte {4'h0,nibble}).
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   RX         serial input, idle high, asynchronous to clk
//   BATT_RX    last received battery reading (12 bits)
//   CURR_RX    last received current reading (12 bits)
//   TORQUE_RX  last received torque reading (12 bits)
//   vld        one-cycle pulse when the three readings update
//   err        one-cycle pulse when a packet is dropped
//
// UART FSM:
//   state   | meaning
//   U_IDLE  | waiting for a falling edge on rx_s
//   U_START | counting to the middle of the start bit
//   U_DATA  | sampling 8 data bits, LSB first
//   U_STOP  | sampling the stop bit
//
// Parser FSM:
//   state     | meaning
//   P_HUNT_AA | looking for the first header byte
//   P_HUNT_55 | first header seen, looking for the second
//   P_PAYLOAD | collecting six payload bytes (index 0..5)

module telemetry_rx #(
  parameter int BAUD_CYC = 2604,
  parameter int TMO_CYC  = 32768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] BATT_RX,
  output logic [11:0] CURR_RX,
  output logic [11:0] TORQUE_RX,
  output logic        vld,
  output logic        err
);

  localparam int BW = $clog2(BAUD_CYC + 1);
  localparam int TW = $clog2(TMO_CYC + 1);

  localparam logic [BW-1:0] HALF_LOAD = BW'(BAUD_CYC / 2 - 1);
  localparam logic [BW-1:0] FULL_LOAD = BW'(BAUD_CYC - 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TMO_CYC - 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
  typedef enum logic [1:0] {P_HUNT_AA, P_HUNT_55, P_PAYLOAD} parse_state_t;

  logic rx_m, rx_s, rx_prev;

  uart_state_t    ustate;
  logic [BW-1:0]  baud_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic           byte_rdy;
  logic [7:0]     byte_data;
  logic           frame_err;

  parse_state_t   pstate;
  logic [2:0]     idx;
  logic [TW-1:0]  tmo_cnt;
  logic [11:0]    sh_batt, sh_curr, sh_torq;

  // rx_prev gives the falling-edge detect; presetting it high also means a
  // line stuck low after a framing error cannot restart a byte until it has
  // gone high again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= RX;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  // Down-counter loaded on the edge cycle; reaching zero marks the sample
  // point, so the start sample lands BAUD_CYC/2 cycles after the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ustate    <= U_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      byte_rdy  <= 1'b0;
      byte_data <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
      case (ustate)
        U_IDLE: begin
          if (!rx_s && rx_prev) begin
            ustate   <= U_START;
            baud_cnt <= HALF_LOAD;
          end
        end
        U_START: begin
          if (baud_cnt == '0) begin
            if (rx_s) begin
              ustate <= U_IDLE;
            end else begin
              ustate   <= U_DATA;
              baud_cnt <= FULL_LOAD;
              bit_cnt  <= '0;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        U_DATA: begin
          if (baud_cnt == '0) begin
            shift    <= {rx_s, shift[7:1]};
            baud_cnt <= FULL_LOAD;
            if (bit_cnt == 3'd7) ustate <= U_STOP;
            else                 bit_cnt <= bit_cnt + 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        U_STOP: begin
          if (baud_cnt == '0) begin
            ustate <= U_IDLE;
            if (rx_s) begin
              byte_rdy  <= 1'b1;
              byte_data <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: ustate <= U_IDLE;
      endcase
    end
  end

  // A byte arriving in the same cycle the timeout would expire takes priority
  // and reloads the counter. vld and err come from mutually exclusive branches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pstate    <= P_HUNT_AA;
      idx       <= '0;
      tmo_cnt   <= '0;
      sh_batt   <= '0;
      sh_curr   <= '0;
      sh_torq   <= '0;
      BATT_RX   <= '0;
      CURR_RX   <= '0;
      TORQUE_RX <= '0;
      vld       <= 1'b0;
      err       <= 1'b0;
    end else begin
      vld <= 1'b0;
      err <= 1'b0;
      if (byte_rdy) begin
        tmo_cnt <= TMO_LOAD;
        case (pstate)
          P_HUNT_AA: begin
            if (byte_data == 8'hAA) pstate <= P_HUNT_55;
          end
          P_HUNT_55: begin
            if (byte_data == 8'h55) begin
              pstate <= P_PAYLOAD;
              idx    <= '0;
            end else if (byte_data != 8'hAA) begin
              pstate <= P_HUNT_AA;
            end
          end
          P_PAYLOAD: begin
            if (!idx[0]) begin
              if (byte_data[7:4] != 4'h0) begin
                err    <= 1'b1;
                pstate <= P_HUNT_AA;
              end else begin
                case (idx[2:1])
                  2'd0:    sh_batt[11:8] <= byte_data[3:0];
                  2'd1:    sh_curr[11:8] <= byte_data[3:0];
                  default: sh_torq[11:8] <= byte_data[3:0];
                endcase
                idx <= idx + 1'b1;
              end
            end else begin
              case (idx[2:1])
                2'd0: sh_batt[7:0] <= byte_data;
                2'd1: sh_curr[7:0] <= byte_data;
                default: begin
                  sh_torq[7:0] <= byte_data;
                  BATT_RX      <= sh_batt;
                  CURR_RX      <= sh_curr;
                  TORQUE_RX    <= {sh_torq[11:8], byte_data};
                  vld          <= 1'b1;
                  pstate       <= P_HUNT_AA;
                end
              endcase
              idx <= idx + 1'b1;
            end
          end
          default: pstate <= P_HUNT_AA;
        endcase
      end else if (frame_err) begin
        err    <= 1'b1;
        pstate <= P_HUNT_AA;
      end else if (pstate != P_HUNT_AA) begin
        if (tmo_cnt == '0) begin
          err    <= 1'b1;
          pstate <= P_HUNT_AA;
        end else begin
          tmo_cnt <= tmo_cnt - 1'b1;
        end
      end
    end
  end

endmodule
